// File: rtl/mem_rd_splitter.sv
// Read datamover: splits byte-granular read commands into 4 KB-safe AXI4 INCR bursts
// and streams the returned data. Define MEM_RD_SPLITTER_STATS_EN for burst/beat counters.
module mem_rd_splitter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 512,
    parameter int ID_WIDTH        = 1,
    parameter int LEN_WIDTH       = 32,
    parameter int MAX_BURST_BEATS = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  mem_clk,
    input  logic                  mem_aresetn,

    input  logic                  s_cmd_valid,
    output logic                  s_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] s_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  s_cmd_length,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,

    output logic                  m_sts_valid,
    input  logic                  m_sts_ready,
    output logic [1:0]            m_sts_error
`ifdef MEM_RD_SPLITTER_STATS_EN
    ,
    output logic [31:0]           stat_bursts,
    output logic [31:0]           stat_beats
`endif
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int OFF        = $clog2(BEAT_BYTES);
    localparam int BA_W       = ADDR_WIDTH - OFF;
    localparam int RW         = LEN_WIDTH - OFF;
    localparam int PAGE_BEATS = 4096 / BEAT_BYTES;
    localparam int PG_W       = $clog2(PAGE_BEATS);
    localparam int NW         = 9;
    localparam int OW         = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_STATUS} state_t;

    state_t          state_q, state_d;
    logic            live_q;
    logic [BA_W-1:0] baddr_q;
    logic [RW-1:0]   rem_q;
    logic [OW-1:0]   outst_q;
    logic            ar_done_q;
    logic [1:0]      err_q;
    logic            active;

    logic [NW-1:0]   n_rem, n_page, n_burst;
    logic            last_burst, outst_full;
    logic            cmd_hs, ar_hs, r_hs, rl_hs, sts_hs, cmd_zero;
    logic            unused_rid;

    assign unused_rid = ^m_axi_rid;

    // Burst size: remaining beats, capped by max burst and distance to the 4 KB page end.
    always_comb begin
        n_rem   = (rem_q > RW'(MAX_BURST_BEATS)) ? NW'(MAX_BURST_BEATS) : NW'(rem_q);
        n_page  = NW'(PAGE_BEATS) - NW'(baddr_q[PG_W-1:0]);
        n_burst = (n_page < n_rem) ? n_page : n_rem;
    end

    assign last_burst = (rem_q == RW'(n_burst));
    assign outst_full = (outst_q == OW'(MAX_OUTSTANDING));
    assign cmd_zero   = ~|s_cmd_length[LEN_WIDTH-1:OFF];

    assign cmd_hs = s_cmd_valid & s_cmd_ready;
    assign ar_hs  = m_axi_arvalid & m_axi_arready;
    assign r_hs   = m_axi_rvalid & m_axi_rready;
    assign rl_hs  = r_hs & m_axi_rlast;
    assign sts_hs = m_sts_valid & m_sts_ready;

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = {baddr_q, {OFF{1'b0}}};
    assign m_axi_arlen   = 8'(n_burst - NW'(1));
    assign m_axi_arsize  = 3'(OFF);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;

    // R channel is a straight pass-through, only opened while a command is active.
    assign m_axi_rready  = active & m_axis_tready;
    assign m_axis_tvalid = active & m_axi_rvalid;
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tlast  = m_axi_rlast & ar_done_q & (outst_q == OW'(1));

    assign m_sts_error = err_q;

    always_ff @(posedge mem_clk or negedge mem_aresetn) begin
        if (!mem_aresetn) begin
            state_q <= S_IDLE;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    // arvalid depends only on registered state, and outst_q cannot rise without an AR
    // handshake, so once raised it stays up with stable fields until accepted.
    always_comb begin
        state_d       = state_q;
        s_cmd_ready   = 1'b0;
        m_axi_arvalid = 1'b0;
        m_sts_valid   = 1'b0;
        active        = 1'b0;
        case (state_q)
            S_IDLE: begin
                s_cmd_ready = live_q;
                if (s_cmd_valid && live_q)
                    state_d = cmd_zero ? S_STATUS : S_ISSUE;
            end
            S_ISSUE: begin
                active        = 1'b1;
                m_axi_arvalid = ~outst_full;
                if (m_axi_arvalid && m_axi_arready && last_burst)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                active = 1'b1;
                if (outst_q == '0)
                    state_d = S_STATUS;
            end
            S_STATUS: begin
                m_sts_valid = 1'b1;
                if (m_sts_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or negedge mem_aresetn) begin
        if (!mem_aresetn) begin
            baddr_q   <= '0;
            rem_q     <= '0;
            outst_q   <= '0;
            ar_done_q <= 1'b0;
            err_q     <= 2'b00;
        end else begin
            if (cmd_hs) begin
                baddr_q   <= s_cmd_addr[ADDR_WIDTH-1:OFF];
                rem_q     <= s_cmd_length[LEN_WIDTH-1:OFF];
                ar_done_q <= 1'b0;
                err_q     <= {(|s_cmd_addr[OFF-1:0]) | (|s_cmd_length[OFF-1:0]), 1'b0};
            end
            if (ar_hs) begin
                baddr_q <= baddr_q + BA_W'(n_burst);
                rem_q   <= rem_q - RW'(n_burst);
                if (last_burst)
                    ar_done_q <= 1'b1;
            end
            if (ar_hs && !rl_hs)
                outst_q <= outst_q + OW'(1);
            else if (rl_hs && !ar_hs)
                outst_q <= outst_q - OW'(1);
            if (r_hs && (m_axi_rresp != 2'b00))
                err_q[0] <= 1'b1;
            if (sts_hs) begin
                err_q     <= 2'b00;
                ar_done_q <= 1'b0;
            end
        end
    end

`ifdef MEM_RD_SPLITTER_STATS_EN
    always_ff @(posedge mem_clk or negedge mem_aresetn) begin
        if (!mem_aresetn) begin
            stat_bursts <= '0;
            stat_beats  <= '0;
        end else begin
            if (ar_hs) stat_bursts <= stat_bursts + 32'd1;
            if (r_hs)  stat_beats  <= stat_beats + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_mem_rd_splitter.sv
// Directed bench for mem_rd_splitter with a small AXI4 read slave model.
module tb_mem_rd_splitter;

    logic         mem_clk = 1'b0;
    logic         mem_aresetn = 1'b0;
    logic         s_cmd_valid = 1'b0, s_cmd_ready;
    logic [31:0]  s_cmd_addr = '0, s_cmd_length = '0;
    logic [0:0]   m_axi_arid;
    logic [31:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arlock;
    logic [3:0]   m_axi_arcache;
    logic [2:0]   m_axi_arprot;
    logic         m_axi_arvalid, m_axi_arready = 1'b1;
    logic [0:0]   m_axi_rid = '0;
    logic [511:0] m_axi_rdata = '0;
    logic [1:0]   m_axi_rresp = '0;
    logic         m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0, m_axi_rready;
    logic [511:0] m_axis_tdata;
    logic         m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b1;
    logic         m_sts_valid, m_sts_ready = 1'b1;
    logic [1:0]   m_sts_error;

    mem_rd_splitter dut (
        .mem_clk(mem_clk), .mem_aresetn(mem_aresetn),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_cmd_addr(s_cmd_addr), .s_cmd_length(s_cmd_length),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .m_sts_valid(m_sts_valid), .m_sts_ready(m_sts_ready), .m_sts_error(m_sts_error)
    );

    always #5 mem_clk = ~mem_clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    bit r_en = 1'b1, t_bp = 1'b0, ar_bp = 1'b0, cmd_drop = 1'b0;
    bit rq[$];
    logic [31:0] ar_addr[$];
    logic [7:0]  ar_len[$];
    int n_beats, n_tlast, tlast_at, outst, max_out, sts_cnt, r_idx, err_at, td_bad;
    int ar_viol = 0;
    logic [1:0]  sts_err;
    logic [31:0] rseq = 32'h1000;
    logic        prev_arv = 1'b0;
    logic [31:0] prev_araddr;
    logic [7:0]  prev_arlen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        ar_addr.delete(); ar_len.delete();
        n_beats = 0; n_tlast = 0; tlast_at = 0; outst = 0; max_out = 0;
        sts_cnt = 0; r_idx = 0; err_at = -1; td_bad = 0; sts_err = 2'bxx;
    endtask

    // One cycle: drive at negedge, observe 1 ns later, handshakes land on the next posedge.
    task automatic step();
        @(negedge mem_clk);
        cyc++;
        if (cmd_drop) begin s_cmd_valid = 1'b0; cmd_drop = 1'b0; end
        m_axis_tready = t_bp ? (cyc % 3 != 0) : 1'b1;
        m_axi_arready = ar_bp ? (cyc % 2 == 0) : 1'b1;
        if (r_en && rq.size() > 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rlast  = rq[0];
            m_axi_rresp  = (r_idx == err_at) ? 2'b10 : 2'b00;
            m_axi_rdata  = {16{rseq}};
        end else begin
            m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
        end
        #1;
        if (prev_arv && !(m_axi_arvalid && m_axi_araddr == prev_araddr && m_axi_arlen == prev_arlen))
            ar_viol++;
        prev_arv    = m_axi_arvalid && !m_axi_arready;
        prev_araddr = m_axi_araddr;
        prev_arlen  = m_axi_arlen;
        if (m_axi_arvalid && m_axi_arready) begin
            ar_addr.push_back(m_axi_araddr);
            ar_len.push_back(m_axi_arlen);
            for (int i = 0; i <= int'(m_axi_arlen); i++) rq.push_back(i == int'(m_axi_arlen));
            outst++;
            if (outst > max_out) max_out = outst;
        end
        if (m_axis_tvalid && m_axis_tready) begin
            n_beats++;
            if (m_axis_tdata != {16{rseq}}) td_bad++;
            if (m_axis_tlast) begin n_tlast++; tlast_at = n_beats; end
        end
        if (m_axi_rvalid && m_axi_rready) begin
            if (m_axi_rlast) outst--;
            void'(rq.pop_front());
            r_idx++;
            rseq = rseq + 32'd1;
        end
        if (s_cmd_valid && s_cmd_ready) cmd_drop = 1'b1;
        if (m_sts_valid && m_sts_ready) begin sts_cnt++; sts_err = m_sts_error; end
    endtask

    task automatic start_cmd(input logic [31:0] a, input logic [31:0] l);
        clear_obs();
        s_cmd_addr = a; s_cmd_length = l; s_cmd_valid = 1'b1;
    endtask

    task automatic wait_sts(input string tag, input int budget);
        for (int c = 0; c < budget && sts_cnt == 0; c++) step();
        chk({tag, "_sts_seen"}, sts_cnt, 1);
    endtask

    task automatic check_stream(input string tag, input int beats, input logic [1:0] err);
        chk({tag, "_beats"}, n_beats, beats);
        chk({tag, "_ntlast"}, n_tlast, (beats > 0) ? 1 : 0);
        chk({tag, "_tlast_at"}, tlast_at, beats);
        chk({tag, "_tdata"}, td_bad, 0);
        chk({tag, "_err"}, sts_err, err);
    endtask

    initial begin
        clear_obs();
        #1;
        chk("rst_cmd_ready", s_cmd_ready, 0);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_sts_valid", m_sts_valid, 0);
        step(); step();
        mem_aresetn = 1'b1;
        step(); step();
        chk("idle_cmd_ready", s_cmd_ready, 1);
        chk("arsize", m_axi_arsize, 3'd6);
        chk("arburst", m_axi_arburst, 2'b01);
        chk("arcache", m_axi_arcache, 4'b0011);
        chk("arid_lock_prot", {m_axi_arid, m_axi_arlock, m_axi_arprot}, 0);

        // two full 4 KB bursts
        start_cmd(32'h0, 32'h2000);
        wait_sts("t1", 500);
        chk("t1_nar", ar_addr.size(), 2);
        if (ar_addr.size() == 2) begin
            chk("t1_ar0", {ar_addr[0], ar_len[0]}, {32'h0, 8'd63});
            chk("t1_ar1", {ar_addr[1], ar_len[1]}, {32'h1000, 8'd63});
        end
        check_stream("t1", 128, 2'b00);

        // 4 KB crossing, with AR and stream backpressure
        ar_bp = 1'b1; t_bp = 1'b1;
        start_cmd(32'hFC0, 32'h100);
        wait_sts("t2", 200);
        chk("t2_nar", ar_addr.size(), 2);
        if (ar_addr.size() == 2) begin
            chk("t2_ar0", {ar_addr[0], ar_len[0]}, {32'hFC0, 8'd0});
            chk("t2_ar1", {ar_addr[1], ar_len[1]}, {32'h1000, 8'd2});
        end
        check_stream("t2", 4, 2'b00);
        ar_bp = 1'b0; t_bp = 1'b0;

        // outstanding limit with R withheld
        r_en = 1'b0;
        start_cmd(32'h0, 32'h10000);
        for (int c = 0; c < 40; c++) step();
        chk("t3_ar_cap", ar_addr.size(), 8);
        chk("t3_arv_held", m_axi_arvalid, 0);
        r_en = 1'b1;
        wait_sts("t3", 3000);
        chk("t3_nar", ar_addr.size(), 16);
        chk("t3_max_out", max_out, 8);
        if (ar_addr.size() == 16) chk("t3_ar15", {ar_addr[15], ar_len[15]}, {32'hF000, 8'd63});
        check_stream("t3", 1024, 2'b00);

        // SLVERR on a mid-burst beat
        start_cmd(32'h0, 32'h400);
        err_at = 5;
        wait_sts("t4", 200);
        check_stream("t4", 16, 2'b01);

        // unaligned address and length: truncated
        start_cmd(32'h21, 32'h45);
        wait_sts("t5", 100);
        chk("t5_nar", ar_addr.size(), 1);
        if (ar_addr.size() == 1) chk("t5_ar0", {ar_addr[0], ar_len[0]}, {32'h0, 8'd0});
        check_stream("t5", 1, 2'b10);

        // zero length: status only
        start_cmd(32'h80, 32'h0);
        wait_sts("t6", 50);
        chk("t6_nar", ar_addr.size(), 0);
        check_stream("t6", 0, 2'b00);

        // reset in DRAIN
        r_en = 1'b0;
        start_cmd(32'h0, 32'h2000);
        for (int c = 0; c < 10; c++) step();
        chk("t7_nar_pre", ar_addr.size(), 2);
        mem_aresetn = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
        #1;
        chk("t7_rst_arvalid", m_axi_arvalid, 0);
        chk("t7_rst_tvalid", m_axis_tvalid, 0);
        chk("t7_rst_sts_valid", m_sts_valid, 0);
        chk("t7_rst_cmd_ready", s_cmd_ready, 0);
        rq.delete(); r_en = 1'b1; outst = 0; prev_arv = 1'b0;
        step(); step();
        mem_aresetn = 1'b1;
        step(); step();
        chk("t7_post_cmd_ready", s_cmd_ready, 1);
        chk("t7_no_sts", sts_cnt, 0);
        start_cmd(32'h40, 32'h80);
        wait_sts("t7", 100);
        chk("t7_nar", ar_addr.size(), 1);
        if (ar_addr.size() == 1) chk("t7_ar0", {ar_addr[0], ar_len[0]}, {32'h40, 8'd1});
        check_stream("t7", 2, 2'b00);

        chk("ar_stable", ar_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
